// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: PC-mux select codes, FSM states and
// the next-PC source priority encoder.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        PC_SRC_PLUS4  = 3'd0,
        PC_SRC_JALR   = 3'd1,
        PC_SRC_BRANCH = 3'd2,
        PC_SRC_JAL    = 3'd3,
        PC_SRC_MTVEC  = 3'd4,
        PC_SRC_MEPC   = 3'd5
    } pc_src_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_TRAP  = 2'd2
    } seq_state_t;

    // Several decode flags may be set at once; mret beats jalr beats jal beats branch.
    function automatic pc_src_t next_pc_src(
        input logic is_mret,
        input logic is_jalr,
        input logic is_jal,
        input logic is_branch,
        input logic br_taken
    );
        pc_src_t src;
        if (is_mret)
            src = PC_SRC_MEPC;
        else if (is_jalr)
            src = PC_SRC_JALR;
        else if (is_jal)
            src = PC_SRC_JAL;
        else if (is_branch && br_taken)
            src = PC_SRC_BRANCH;
        else
            src = PC_SRC_PLUS4;
        return src;
    endfunction

endpackage

// File: rtl/pc_sequencer_intr_sync.sv
// Two-flop synchronizer for the external interrupt line; only instantiated
// by pc_sequencer when INTR_SYNC_EN is defined.
module intr_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/EXEC/TRAP sequencer driving the PC mux and PC/IR enables.
// Define INTR_SYNC_EN to route intr through a 2-flop synchronizer before the pending latch.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int INSTRET_W     = 32,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 imem_ready,
    input  logic                 instr_done,
    input  logic                 is_jal,
    input  logic                 is_jalr,
    input  logic                 is_branch,
    input  logic                 br_taken,
    input  logic                 is_mret,
    input  logic                 intr,
    input  logic                 mie,
    output logic                 imem_req,
    output logic [2:0]           pcSource,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 mepc_we,
    output logic                 mie_clr,
    output logic                 mie_set,
    output logic                 fetch_err,
    output logic [INSTRET_W-1:0] instret
);

    localparam int TO_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);

    seq_state_t           state_q, state_d;
    logic                 pending_q, pending_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    pc_src_t              pc_src;
    logic                 intr_s;
    logic                 irq_now;

`ifdef INTR_SYNC_EN
    intr_sync u_intr_sync (
        .clk (CLK),
        .rst (RST),
        .d   (intr),
        .q   (intr_s)
    );
    // The synchronized path is only trusted once it has landed in the latch.
    assign irq_now = pending_q;
`else
    assign intr_s  = intr;
    assign irq_now = pending_q | intr;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_FETCH;
            pending_q <= 1'b0;
            instret_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            instret_q <= instret_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | intr_s;
        instret_d = instret_q;
        to_cnt_d  = to_cnt_q;
        pc_src    = PC_SRC_PLUS4;
        imem_req  = 1'b0;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mepc_we   = 1'b0;
        mie_clr   = 1'b0;
        mie_set   = 1'b0;
        fetch_err = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    to_cnt_d = '0;
                    state_d  = ST_EXEC;
                end else if (FETCH_TIMEOUT != 0) begin
                    // Request stays up after a timeout; the counter just restarts.
                    if (to_cnt_q == TO_W'(FETCH_TIMEOUT - 1)) begin
                        fetch_err = 1'b1;
                        to_cnt_d  = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end

            ST_EXEC: begin
                if (instr_done) begin
                    pc_write  = 1'b1;
                    pc_src    = next_pc_src(is_mret, is_jalr, is_jal, is_branch, br_taken);
                    mie_set   = is_mret;
                    instret_d = instret_q + 1'b1;
                    // mie is only restored after mret commits, so never trap at that boundary.
                    if (irq_now && mie && !is_mret) begin
                        pending_d = 1'b0;
                        state_d   = ST_TRAP;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_TRAP: begin
                mepc_we  = 1'b1;
                pc_write = 1'b1;
                mie_clr  = 1'b1;
                pc_src   = PC_SRC_MTVEC;
                state_d  = ST_FETCH;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign pcSource = pc_src;
    assign instret  = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed instructions push expected
// strobe events; a monitor pops and compares each time the DUT strobes.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imem_ready = 1'b0;
    logic        instr_done = 1'b0;
    logic        is_jal = 1'b0;
    logic        is_jalr = 1'b0;
    logic        is_branch = 1'b0;
    logic        br_taken = 1'b0;
    logic        is_mret = 1'b0;
    logic        intr = 1'b0;
    logic        mie = 1'b0;
    logic        imem_req;
    logic [2:0]  pcSource;
    logic        pc_write;
    logic        ir_write;
    logic        mepc_we;
    logic        mie_clr;
    logic        mie_set;
    logic        fetch_err;
    logic [31:0] instret;

    typedef struct packed {
        logic        ir;
        logic        pcw;
        logic [2:0]  src;
        logic        mepc;
        logic        mclr;
        logic        mset;
        logic        ferr;
        logic        req;
        logic [31:0] cnt;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_instret = 0;

    pc_sequencer #(
        .INSTRET_W     (32),
        .FETCH_TIMEOUT (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imem_ready (imem_ready),
        .instr_done (instr_done),
        .is_jal     (is_jal),
        .is_jalr    (is_jalr),
        .is_branch  (is_branch),
        .br_taken   (br_taken),
        .is_mret    (is_mret),
        .intr       (intr),
        .mie        (mie),
        .imem_req   (imem_req),
        .pcSource   (pcSource),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mepc_we    (mepc_we),
        .mie_clr    (mie_clr),
        .mie_set    (mie_set),
        .fetch_err  (fetch_err),
        .instret    (instret)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    function automatic ev_t mk_ev(input logic ir, input logic pcw, input logic [2:0] src,
                                  input logic mepc, input logic mclr, input logic mset,
                                  input logic ferr, input logic req, input logic [31:0] cnt);
        ev_t e;
        e.ir = ir; e.pcw = pcw; e.src = src; e.mepc = mepc; e.mclr = mclr;
        e.mset = mset; e.ferr = ferr; e.req = req; e.cnt = cnt;
        return e;
    endfunction

    task automatic fetch(input logic intr_in_fetch);
        exp_q.push_back(mk_ev(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_instret));
        imem_ready = 1'b1;
        if (intr_in_fetch) intr = 1'b1;
        tick();
        imem_ready = 1'b0;
        if (intr_in_fetch) intr = 1'b0;
    endtask

    // flags = {mret, jalr, jal, branch, taken}
    task automatic exec(input logic [4:0] flags, input logic [2:0] exp_src,
                        input logic exp_trap, input logic intr_at_done);
        tick();
        {is_mret, is_jalr, is_jal, is_branch, br_taken} = flags;
        instr_done = 1'b1;
        if (intr_at_done) intr = 1'b1;
        exp_q.push_back(mk_ev(1'b0, 1'b1, exp_src, 1'b0, 1'b0, exp_src == 3'd5, 1'b0, 1'b0,
                              exp_instret));
        tick();
        {is_mret, is_jalr, is_jal, is_branch, br_taken} = 5'b0;
        instr_done = 1'b0;
        if (intr_at_done) intr = 1'b0;
        exp_instret = exp_instret + 1;
        if (exp_trap) begin
            exp_q.push_back(mk_ev(1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_instret));
            tick();
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge CLK);
                if (!RST && (ir_write || pc_write || fetch_err || mepc_we || mie_clr || mie_set)) begin
                    ev_t got, exp;
                    got = mk_ev(ir_write, pc_write, pcSource, mepc_we, mie_clr, mie_set,
                                fetch_err, imem_req, instret);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL event unexpected: got %h, expected none", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL event: got ir=%b pcw=%b src=%0d mepc=%b mclr=%b mset=%b ferr=%b req=%b instret=%0d, expected ir=%b pcw=%b src=%0d mepc=%b mclr=%b mset=%b ferr=%b req=%b instret=%0d",
                                     got.ir, got.pcw, got.src, got.mepc, got.mclr, got.mset, got.ferr, got.req, got.cnt,
                                     exp.ir, exp.pcw, exp.src, exp.mepc, exp.mclr, exp.mset, exp.ferr, exp.req, exp.cnt);
                        end else begin
                            $display("event ir=%b pcw=%b src=%0d mepc=%b mclr=%b mset=%b ferr=%b instret=%0d ok",
                                     got.ir, got.pcw, got.src, got.mepc, got.mclr, got.mset, got.ferr, got.cnt);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("reset_instret", instret, 0);
        check("reset_pc_write", {31'b0, pc_write}, 0);
        check("reset_pcSource", {29'b0, pcSource}, 0);
        check("reset_imem_req", {31'b0, imem_req}, 1);
        check("reset_fetch_err", {31'b0, fetch_err}, 0);
        RST = 1'b0;

        // Plain instruction
        fetch(1'b0);
        exec(5'b00000, 3'd0, 1'b0, 1'b0);
        check("instret_after_first", instret, 1);

        // jalr, jal, branch taken, branch not taken, jalr+jal priority
        fetch(1'b0); exec(5'b01000, 3'd1, 1'b0, 1'b0);
        fetch(1'b0); exec(5'b00100, 3'd3, 1'b0, 1'b0);
        fetch(1'b0); exec(5'b00011, 3'd2, 1'b0, 1'b0);
        fetch(1'b0); exec(5'b00010, 3'd0, 1'b0, 1'b0);
        fetch(1'b0); exec(5'b01100, 3'd1, 1'b0, 1'b0);
        check("instret_after_six", instret, 6);

        // Interrupt latched in FETCH, taken after a JAL
        mie = 1'b1;
        fetch(1'b1); exec(5'b00100, 3'd3, 1'b1, 1'b0);
        // Interrupt arriving with instr_done is taken at that boundary
        fetch(1'b0); exec(5'b00011, 3'd2, 1'b1, 1'b1);
        // No leftover pending: next instruction retires without trap
        fetch(1'b0); exec(5'b00000, 3'd0, 1'b0, 1'b0);

        // mie=0 holds off the trap for three instructions
        mie = 1'b0;
        intr = 1'b1;
        repeat (3) begin
            fetch(1'b0); exec(5'b00000, 3'd0, 1'b0, 1'b0);
        end
        intr = 1'b0;
        mie = 1'b1;
        fetch(1'b0); exec(5'b00000, 3'd0, 1'b1, 1'b0);

        // No trap at mret boundary; pending taken after the following instruction
        fetch(1'b1); exec(5'b10000, 3'd5, 1'b0, 1'b0);
        fetch(1'b0); exec(5'b00000, 3'd0, 1'b1, 1'b0);
        check("instret_after_irq", instret, 15);

        // Fetch timeout: err on waiting cycles 4 and 8; instr_done in FETCH ignored
        exp_q.push_back(mk_ev(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, exp_instret));
        exp_q.push_back(mk_ev(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, exp_instret));
        for (int i = 1; i <= 9; i++) begin
            if (i == 2) begin
                instr_done = 1'b1;
                is_jal = 1'b1;
            end
            @(negedge CLK);
            check($sformatf("imem_req_wait%0d", i), {31'b0, imem_req}, 1);
            if (i == 2) check("done_in_fetch_pc_write", {31'b0, pc_write}, 0);
            tick();
            instr_done = 1'b0;
            is_jal = 1'b0;
        end
        check("instret_after_timeout", instret, 15);

        // Asynchronous reset while in EXEC
        fetch(1'b0);
        #3;
        RST = 1'b1;
        #1;
        check("rst_exec_instret", instret, 0);
        check("rst_exec_imem_req", {31'b0, imem_req}, 1);
        check("rst_exec_pc_write", {31'b0, pc_write}, 0);
        tick();
        RST = 1'b0;
        exp_instret = 0;
        fetch(1'b0); exec(5'b00100, 3'd3, 1'b0, 1'b0);
        check("instret_after_reset", instret, 1);

        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control FSM that sequences the program-counter datapath.
- Each instruction: fetch handshake, wait for execute completion, then select the next-PC source code (pcSource) and pulse the PC-register write enable.
- Latches external interrupts and performs trap entry: save the resumed PC to mepc, vector through mtvec. Handles mret return.
- Sits between the decoder/branch-condition logic and the PC mux/PC register.

Parameters:
- INSTRET_W, 32, width of retired-instruction counter.
- FETCH_TIMEOUT, 255, max cycles waiting imem_ready before fetch_err pulse (0 = no timeout).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- imem_ready  in  1  instruction memory has returned data for current imem_req.
- instr_done  in  1  execute/writeback of current instruction complete (one-cycle pulse, EXEC only).
- is_jal  in  1  decoded JAL.
- is_jalr  in  1  decoded JALR.
- is_branch  in  1  decoded conditional branch.
- br_taken  in  1  branch condition true (valid with instr_done).
- is_mret  in  1  decoded MRET.
- intr  in  1  external interrupt request, level.
- mie  in  1  machine interrupt enable from CSR file.
- imem_req  out  1  fetch request.
- pcSource  out  3  select code to PC mux.
- pc_write  out  1  PC register load enable.
- ir_write  out  1  instruction register load enable.
- mepc_we  out  1  write current PC into mepc.
- mie_clr  out  1  clear mie (trap entry).
- mie_set  out  1  restore mie (mret).
- fetch_err  out  1  fetch timeout pulse.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- States: FETCH, EXEC, TRAP. Reset → FETCH.
- Reset values: all pulse outputs 0, pcSource 0, instret 0, pending flag 0, timeout counter 0.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_write=1 same cycle; next state EXEC.
  - Otherwise increment timeout counter. When count reaches FETCH_TIMEOUT (nonzero): fetch_err=1 for one cycle, counter clears, stay in FETCH with request held.
- EXEC:
  - Outputs idle until instr_done.
  - On instr_done: pc_write=1; instret+1 (wraps modulo 2^INSTRET_W).
  - pcSource priority: is_mret→5 (plus mie_set=1); is_jalr→1; is_jal→3; is_branch&br_taken→2; else 0.
  - Next state: TRAP if (pending|intr)&mie&!is_mret, else FETCH.
- TRAP (one cycle): mepc_we=1 (PC register already holds next instruction address); pcSource=4; pc_write=1; mie_clr=1; pending cleared; next FETCH.
- pcSource is combinational from state/inputs and equals 0 whenever pc_write=0.
- Interrupt latch: pending set on intr=1 in any state; cleared only on TRAP entry.
  - intr arriving in the same cycle as instr_done is taken at that boundary.
  - mie=0 keeps pending set; trap is taken at the first instruction boundary after mie returns to 1.
- No trap at the mret boundary (mie restore takes effect one cycle later); pending trap is taken after the next instruction.
- instr_done outside EXEC is ignored. Simultaneous decode flags resolved by the priority above.
- RST mid-operation: immediate return to reset values; in-flight fetch abandoned.

Optional Feature:
- INTR_SYNC_EN.
- Defined: intr passes through a 2-flop synchronizer (reset 0) before the pending latch; interrupt-to-pending latency is 3 cycles.
- Undefined: intr feeds the latch directly (1-cycle latency); same-cycle instr_done capture applies only in this mode.

Decomposition:
- Package pc_seq_pkg:
  - typedef enum logic [2:0] pc_src_t {PC_SRC_PLUS4=0, PC_SRC_JALR=1, PC_SRC_BRANCH=2, PC_SRC_JAL=3, PC_SRC_MTVEC=4, PC_SRC_MEPC=5}.
  - typedef enum logic [1:0] seq_state_t {ST_FETCH, ST_EXEC, ST_TRAP}.
- Sub-module intr_sync: 2-flop synchronizer, instantiated only under INTR_SYNC_EN.

Test Plan:
- Reset, imem_ready=1 next cycle, instr_done with no flags → ir_write pulse, then pc_write with pcSource=0, instret=1.
- Four instructions flagged jalr / jal / branch taken / branch not-taken → pcSource sequence 1,3,2,0; instret=4.
- mie=1, intr pulsed during FETCH; instruction completes as JAL → pc_write pcSource=3, next cycle TRAP: mepc_we=1, pcSource=4, mie_clr=1, then FETCH.
- intr=1 with mie=0 for 3 instructions, then mie=1 → no trap for the 3, trap after the 4th instruction; is_mret → pcSource=5, mie_set=1, no TRAP at that boundary.
- FETCH_TIMEOUT=4, imem_ready held 0 → fetch_err pulse on the 4th waiting cycle, imem_req stays 1; RST asserted in EXEC → state FETCH, instret=0.
